// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage LC-3b pipeline: stage loads/flushes,
// load-use bubble sequencer, LDI/STI two-phase FSM. HAZARD_PERF_CNT_EN enables the perf counters.

// One source-operand dependency check against the ID/EX destination.
module hazard_src_cmp #(
    parameter int REG_W = 3
) (
    input  logic [REG_W-1:0] iSrc,
    input  logic             iUsed,
    input  logic [REG_W-1:0] iDr,
    output logic             oHit
);
    assign oHit = iUsed & (iSrc == iDr);
endmodule

module hazard_stall_ctrl #(
    parameter int REG_W    = 3,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iICacheResp,
    input  logic                     iDCacheResp,
    input  logic                     iMemRead,
    input  logic                     iMemWrite,
    input  logic                     iIndirect,
    input  logic                     iIdExMemRead,
    input  logic [REG_W-1:0]         iIdExDr,
    input  logic [NUM_SRC*REG_W-1:0] iIfIdSrc,
    input  logic [NUM_SRC-1:0]       iIfIdSrcUsed,
    input  logic                     iIfIdMemAccess,
    input  logic                     iIdExCtrlXfer,
    input  logic                     iBrPredicted,
    input  logic                     iBrMispredict,
    input  logic                     iWbRedirect,
    output logic                     oLoadPC,
    output logic                     oLoadIfId,
    output logic                     oLoadIdEx,
    output logic                     oLoadExMem,
    output logic                     oLoadMemWb,
    output logic                     oFlushIfId,
    output logic                     oFlushIdEx,
    output logic                     oFlushExMem,
    output logic                     oFlushMemWb,
    output logic                     oIstate,
    output logic [CNT_W-1:0]         oInstrCount,
    output logic [CNT_W-1:0]         oBubbleCount
);
    typedef enum logic {IND_IDLE, IND_DATA} indState_t;

    typedef struct packed {
        logic pc;
        logic ifId;
        logic idEx;
        logic exMem;
        logic memWb;
    } loadVec_t;

    typedef struct packed {
        logic ifId;
        logic idEx;
        logic exMem;
        logic memWb;
    } flushVec_t;

    // First bubble is the hazard cycle itself, so the counter covers the rest.
    localparam logic [2:0] BUB_INIT = 3'(LOAD_LAT - 1);

    indState_t          state, stateNext;
    logic [2:0]         bubCnt, bubNext;
    logic [NUM_SRC-1:0] srcHit;
    logic               memAcc, stall, pcChange, dep, luHaz, ctrlHaz, hold;
    loadVec_t           load;
    flushVec_t          flush;

    for (genvar k = 0; k < NUM_SRC; k++) begin : gSrc
        hazard_src_cmp #(.REG_W(REG_W)) uCmp (
            .iSrc  (iIfIdSrc[k*REG_W +: REG_W]),
            .iUsed (iIfIdSrcUsed[k]),
            .iDr   (iIdExDr),
            .oHit  (srcHit[k])
        );
    end

    assign memAcc   = iMemRead | iMemWrite;
    // An indirect access always needs a second D-cache round trip, so the
    // pointer phase stalls even when the D-cache answers.
    assign stall    = ~iICacheResp | (memAcc & ~iDCacheResp)
                    | (memAcc & iIndirect & (state == IND_IDLE));
    assign pcChange = iWbRedirect | iBrMispredict;
    assign dep      = |srcHit;
    assign luHaz    = iIdExMemRead & dep;
    assign ctrlHaz  = iIfIdMemAccess & iIdExCtrlXfer;
    assign hold     = luHaz | ctrlHaz | (bubCnt != 3'd0);

    always_comb begin
        stateNext = state;
        case (state)
            IND_IDLE: if (memAcc && iIndirect && iDCacheResp) stateNext = IND_DATA;
            IND_DATA: if (!stall || pcChange) stateNext = IND_IDLE;
            default:  stateNext = IND_IDLE;
        endcase
    end

    always_comb begin
        bubNext = bubCnt;
        if (pcChange)
            bubNext = 3'd0;
        else if (!stall) begin
            if (bubCnt != 3'd0)
                bubNext = bubCnt - 3'd1;
            else if (luHaz)
                bubNext = BUB_INIT;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state  <= IND_IDLE;
            bubCnt <= 3'd0;
        end else begin
            state  <= stateNext;
            bubCnt <= bubNext;
        end
    end

    // Reset forces a fully flushed, frozen pipeline.
    always_comb begin
        load  = '0;
        flush = '1;
        if (!iRst) begin
            load.pc     = ~stall & (~hold | pcChange);
            load.ifId   = (~stall & (~hold | pcChange)) | iBrPredicted;
            load.idEx   = ~stall;
            load.exMem  = ~stall;
            load.memWb  = ~stall;
            flush.ifId  = pcChange | iBrPredicted;
            flush.idEx  = (~stall & hold) | pcChange;
            flush.exMem = pcChange;
            flush.memWb = pcChange;
        end
    end

    assign oLoadPC     = load.pc;
    assign oLoadIfId   = load.ifId;
    assign oLoadIdEx   = load.idEx;
    assign oLoadExMem  = load.exMem;
    assign oLoadMemWb  = load.memWb;
    assign oFlushIfId  = flush.ifId;
    assign oFlushIdEx  = flush.idEx;
    assign oFlushExMem = flush.exMem;
    assign oFlushMemWb = flush.memWb;
    assign oIstate     = ~iRst & (state == IND_DATA);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] instrCnt, bubbleCnt;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            instrCnt  <= '0;
            bubbleCnt <= '0;
        end else if (!stall) begin
            if (instrCnt != '1)
                instrCnt <= instrCnt + CNT_W'(1);
            if (hold && !pcChange && bubbleCnt != '1)
                bubbleCnt <= bubbleCnt + CNT_W'(1);
        end
    end

    assign oInstrCount  = instrCnt;
    assign oBubbleCount = bubbleCnt;
`else
    assign oInstrCount  = '0;
    assign oBubbleCount = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (LOAD_LAT 1 and 3) share stimulus
// and are checked against a cycle-level reference model.
module tb_hazard_stall_ctrl;
    localparam int REG_W = 3, NUM_SRC = 2;
    localparam int CW_A = 4, CW_B = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ic, dc, rd, wr, ind, idExRd, ifIdMem, xfer, brPred, mispred, wbRedir;
    logic [REG_W-1:0] idExDr;
    logic [NUM_SRC*REG_W-1:0] src;
    logic [NUM_SRC-1:0] used;

    // {loadPC, loadIfId, loadIdEx, loadExMem, loadMemWb, flushIfId, flushIdEx, flushExMem, flushMemWb, istate}
    logic [9:0] obsA, obsB;
    logic [CW_A-1:0] icA, bcA;
    logic [CW_B-1:0] icB, bcB;

    hazard_stall_ctrl #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .LOAD_LAT(1), .CNT_W(CW_A)) dutA (
        .iClk(clk), .iRst(rst), .iICacheResp(ic), .iDCacheResp(dc), .iMemRead(rd), .iMemWrite(wr),
        .iIndirect(ind), .iIdExMemRead(idExRd), .iIdExDr(idExDr), .iIfIdSrc(src), .iIfIdSrcUsed(used),
        .iIfIdMemAccess(ifIdMem), .iIdExCtrlXfer(xfer), .iBrPredicted(brPred), .iBrMispredict(mispred),
        .iWbRedirect(wbRedir), .oLoadPC(obsA[9]), .oLoadIfId(obsA[8]), .oLoadIdEx(obsA[7]),
        .oLoadExMem(obsA[6]), .oLoadMemWb(obsA[5]), .oFlushIfId(obsA[4]), .oFlushIdEx(obsA[3]),
        .oFlushExMem(obsA[2]), .oFlushMemWb(obsA[1]), .oIstate(obsA[0]),
        .oInstrCount(icA), .oBubbleCount(bcA));

    hazard_stall_ctrl #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .LOAD_LAT(3), .CNT_W(CW_B)) dutB (
        .iClk(clk), .iRst(rst), .iICacheResp(ic), .iDCacheResp(dc), .iMemRead(rd), .iMemWrite(wr),
        .iIndirect(ind), .iIdExMemRead(idExRd), .iIdExDr(idExDr), .iIfIdSrc(src), .iIfIdSrcUsed(used),
        .iIfIdMemAccess(ifIdMem), .iIdExCtrlXfer(xfer), .iBrPredicted(brPred), .iBrMispredict(mispred),
        .iWbRedirect(wbRedir), .oLoadPC(obsB[9]), .oLoadIfId(obsB[8]), .oLoadIdEx(obsB[7]),
        .oLoadExMem(obsB[6]), .oLoadMemWb(obsB[5]), .oFlushIfId(obsB[4]), .oFlushIdEx(obsB[3]),
        .oFlushExMem(obsB[2]), .oFlushMemWb(obsB[1]), .oIstate(obsB[0]),
        .oInstrCount(icB), .oBubbleCount(bcB));

    int errors = 0, checks = 0;

    // Reference model: remaining held cycles, pointer-phase flag, plain integer counters.
    int  bubLeft[2] = '{0, 0};
    int  icnt[2] = '{0, 0};
    int  bcnt[2] = '{0, 0};
    bit  inData = 0;
    bit  mStall, mPc, mLu, mCtrl;
    logic [9:0] expv[2];
    int  expIc[2], expBc[2];

    function automatic int lat(int j);
        return (j == 0) ? 1 : 3;
    endfunction

    function automatic int cmax(int j);
        return (j == 0) ? (1 << CW_A) - 1 : (1 << CW_B) - 1;
    endfunction

    task automatic setIdle();
        ic = 1; dc = 1; rd = 0; wr = 0; ind = 0; idExRd = 0; idExDr = '0; src = '0; used = '0;
        ifIdMem = 0; xfer = 0; brPred = 0; mispred = 0; wbRedir = 0;
    endtask

    // Called with inputs applied just after a falling edge.
    task automatic apply();
        bit memAcc, dep, hold, lp;
        #1;
        memAcc = rd | wr;
        mStall = !ic || (memAcc && !dc) || (memAcc && ind && !inData);
        mPc    = wbRedir || mispred;
        dep    = 0;
        for (int k = 0; k < NUM_SRC; k++)
            if (used[k] && src[k*REG_W +: REG_W] == idExDr) dep = 1;
        mLu   = idExRd && dep;
        mCtrl = ifIdMem && xfer;
        for (int j = 0; j < 2; j++) begin
            hold = mLu || mCtrl || bubLeft[j] > 0;
            lp = !mStall && (!hold || mPc);
            if (rst) expv[j] = 10'b00000_1111_0;
            else expv[j] = {lp, lp | brPred, {3{!mStall}}, mPc | brPred,
                            (!mStall && hold) || mPc, mPc, mPc, inData};
`ifdef HAZARD_PERF_CNT_EN
            expIc[j] = icnt[j];
            expBc[j] = bcnt[j];
`else
            expIc[j] = 0;
            expBc[j] = 0;
`endif
        end
    endtask

    task automatic tick();
        bit hold;
        for (int j = 0; j < 2; j++) begin
            hold = mLu || mCtrl || bubLeft[j] > 0;
            if (rst) begin
                bubLeft[j] = 0; icnt[j] = 0; bcnt[j] = 0;
            end else begin
                if (!mStall) begin
                    if (icnt[j] < cmax(j)) icnt[j]++;
                    if (hold && !mPc && bcnt[j] < cmax(j)) bcnt[j]++;
                end
                if (mPc) bubLeft[j] = 0;
                else if (!mStall) begin
                    if (bubLeft[j] > 0) bubLeft[j]--;
                    else if (mLu) bubLeft[j] = lat(j) - 1;
                end
            end
        end
        if (rst) inData = 0;
        else if (!inData) inData = (rd || wr) && ind && dc;
        else if (!mStall || mPc) inData = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        setIdle(); rst = 1;
        apply();
        checks++;
        if (obsA !== 10'b00000_1111_0 || obsB !== 10'b00000_1111_0) begin
            errors++; $display("FAIL reset_outputs got A=%b B=%b exp 0000011110", obsA, obsB);
        end
        checks++;
        if (icA !== CW_A'(0) || bcB !== CW_B'(0)) begin
            errors++; $display("FAIL reset_counters got icA=%0d bcB=%0d exp 0", icA, bcB);
        end
        tick();
        rst = 0;
    endtask

    task automatic test_load_use();
        int stallB = 0;
        setIdle(); idExRd = 1; idExDr = 3'd2; src = {3'd0, 3'd2}; used = 2'b01;
        apply();
        checks++;
        if (obsA[9:8] !== 2'b00 || obsA[3] !== 1'b1) begin
            errors++; $display("FAIL lu_bubble_A got %b exp loadPC/IfId=00 flushIdEx=1", obsA);
        end
        checks++;
        if ({obsA, icA, bcA} !== {expv[0], CW_A'(expIc[0]), CW_A'(expBc[0])}) begin
            errors++; $display("FAIL lu_model_A got %b/%0d/%0d exp %b/%0d/%0d", obsA, icA, bcA, expv[0], expIc[0], expBc[0]);
        end
        if (!obsB[9]) stallB++;
        tick();
        for (int c = 2; c <= 6; c++) begin
            setIdle(); ic = (c != 2);
            apply();
            if (c == 3) begin
                checks++;
                if (obsA[9:5] !== 5'b11111) begin
                    errors++; $display("FAIL lu_release_A got %b exp loads 11111", obsA[9:5]);
                end
            end
            checks++;
            if ({obsB, icB, bcB} !== {expv[1], CW_B'(expIc[1]), CW_B'(expBc[1])}) begin
                errors++; $display("FAIL lu_model_B c%0d got %b/%0d/%0d exp %b/%0d/%0d", c, obsB, icB, bcB, expv[1], expIc[1], expBc[1]);
            end
            if (!obsB[9]) stallB++;
            tick();
        end
        checks++;
        if (stallB != 4) begin
            errors++; $display("FAIL lu_multi_B held cycles got %0d exp 4", stallB);
        end
    endtask

    task automatic test_indirect();
        bit dcSeq[6] = '{0, 0, 1, 0, 1, 1};
        bit isSeq[6] = '{0, 0, 0, 1, 1, 0};
        for (int c = 0; c < 6; c++) begin
            setIdle();
            if (c < 5) begin rd = 1; ind = 1; end
            dc = dcSeq[c];
            apply();
            checks++;
            if (obsA[0] !== isSeq[c] || obsA !== expv[0]) begin
                errors++; $display("FAIL indirect c%0d got %b exp %b istate=%0d", c, obsA, expv[0], isSeq[c]);
            end
            if (c == 4) begin
                checks++;
                if (obsA[9:5] !== 5'b11111) begin
                    errors++; $display("FAIL indirect_done got loads %b exp 11111", obsA[9:5]);
                end
            end
            tick();
        end
    endtask

    task automatic test_mispredict();
        setIdle(); idExRd = 1; idExDr = 3'd5; src = {3'd5, 3'd1}; used = 2'b10;
        apply(); tick();
        setIdle(); mispred = 1;
        apply();
        checks++;
        if (obsB[4:1] !== 4'b1111 || obsB[9] !== 1'b1) begin
            errors++; $display("FAIL mispredict_B got %b exp flushes 1111 loadPC 1", obsB);
        end
        tick();
        setIdle();
        apply();
        checks++;
        if (obsB !== expv[1] || obsB[9] !== 1'b1) begin
            errors++; $display("FAIL mispredict_clear_B got %b exp %b", obsB, expv[1]);
        end
        tick();
    endtask

    task automatic test_ctrl_hazard();
        setIdle(); ifIdMem = 1; xfer = 1; brPred = 1;
        apply();
        checks++;
        if (obsA[9] !== 1'b0 || obsA[8] !== 1'b1 || obsA[4:3] !== 2'b11) begin
            errors++; $display("FAIL ctrl_hazard got %b exp loadPC0 loadIfId1 flushIfId1 flushIdEx1", obsA);
        end
        tick();
        setIdle();
        apply();
        checks++;
        if (obsA !== 10'b11111_0000_0 || obsB !== 10'b11111_0000_0) begin
            errors++; $display("FAIL ctrl_release got A=%b B=%b exp 1111100000", obsA, obsB);
        end
        tick();
    endtask

    task automatic test_saturation();
        setIdle(); rst = 1; apply(); tick(); rst = 0;
        for (int c = 0; c < 20; c++) begin apply(); tick(); end
        apply();
        checks++;
        if (icA !== CW_A'(expIc[0]) || icB !== CW_B'(expIc[1])) begin
            errors++; $display("FAIL saturate got icA=%0d icB=%0d exp %0d/%0d", icA, icB, expIc[0], expIc[1]);
        end
        tick();
        rst = 1;
        apply();
        checks++;
        if (obsA[4:1] !== 4'b1111 || obsA[9:5] !== 5'b00000) begin
            errors++; $display("FAIL reset_mid got %b exp loads 0 flushes 1", obsA);
        end
        tick(); rst = 0;
        apply();
        checks++;
        if (icA !== CW_A'(0) || bcA !== CW_A'(0) || icB !== CW_B'(0) || bcB !== CW_B'(0)) begin
            errors++; $display("FAIL reset_clear got %0d %0d %0d %0d exp 0", icA, bcA, icB, bcB);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(63) == 0);
            ic      = ($urandom_range(7) != 0);
            dc      = ($urandom_range(3) != 0);
            rd      = ($urandom_range(3) == 0);
            wr      = ($urandom_range(7) == 0);
            ind     = ($urandom_range(2) == 0);
            idExRd  = $urandom_range(1);
            idExDr  = REG_W'($urandom_range(7));
            src     = (NUM_SRC*REG_W)'($urandom);
            used    = NUM_SRC'($urandom);
            ifIdMem = $urandom_range(1);
            xfer    = ($urandom_range(3) == 0);
            brPred  = ($urandom_range(7) == 0);
            mispred = ($urandom_range(15) == 0);
            wbRedir = ($urandom_range(15) == 0);
            apply();
            checks++;
            if ({obsA, icA, bcA} !== {expv[0], CW_A'(expIc[0]), CW_A'(expBc[0])}) begin
                errors++; $display("FAIL rand_A c%0d got %b/%0d/%0d exp %b/%0d/%0d", c, obsA, icA, bcA, expv[0], expIc[0], expBc[0]);
            end
            checks++;
            if ({obsB, icB, bcB} !== {expv[1], CW_B'(expIc[1]), CW_B'(expBc[1])}) begin
                errors++; $display("FAIL rand_B c%0d got %b/%0d/%0d exp %b/%0d/%0d", c, obsB, icB, bcB, expv[1], expIc[1], expBc[1]);
            end
            tick();
        end
    endtask

    initial begin
        setIdle(); rst = 1;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_indirect();
        test_mispredict();
        test_ctrl_hazard();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
